// File: rtl/aidc_lite_comp_buffer_drain_if.sv
// Outbound word stream of the compression-buffer drain engine.
// The master drives data/valid/last and the slave returns ready.
interface aidc_lite_comp_buffer_drain_if #(
    parameter int DATA_W = 64
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/aidc_lite_comp_buffer_drain.sv
// Walks a wrapping range of compression-buffer entries and streams them out
// one word per cycle, pulsing done once the final word has been accepted.
module aidc_lite_comp_buffer_drain #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   saddr_i,
    input  logic [ADDR_W:0]     wcnt_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ADDR_W-1:0]   raddr_o,
    input  logic [DATA_W-1:0]   rdata_i,
    aidc_lite_comp_buffer_drain_if.master tx
);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_TWO = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t              state_reg,  state_next;
    logic [ADDR_W-1:0]   fptr_reg,   fptr_next;
    logic [ADDR_W:0]     rem_reg,    rem_next;
    logic [DATA_W-1:0]   tdata_reg,  tdata_next;
    logic                tvalid_reg, tvalid_next;
    logic                tlast_reg,  tlast_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            fptr_reg   <= '0;
            rem_reg    <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            fptr_reg   <= fptr_next;
            rem_reg    <= rem_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        fptr_next   = fptr_reg;
        rem_next    = rem_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;

        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    if (wcnt_i == '0) begin
                        state_next = DONE;
                    end else begin
                        fptr_next  = saddr_i;
                        rem_next   = (wcnt_i > CNT_MAX) ? CNT_MAX : wcnt_i;
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                tdata_next  = rdata_i;
                tvalid_next = 1'b1;
                tlast_next  = (rem_reg == CNT_ONE);
                fptr_next   = fptr_reg + PTR_ONE;
                state_next  = SEND;
            end
            SEND: begin
                if (tvalid_reg && tx.tready) begin
                    if (tlast_reg) begin
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        state_next  = DONE;
                    end else begin
                        // Prefetch the next word on the same edge as the
                        // handshake so valid never drops between beats.
                        rem_next   = rem_reg - CNT_ONE;
                        tdata_next = rdata_i;
                        tlast_next = (rem_reg == CNT_TWO);
                        fptr_next  = fptr_reg + PTR_ONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o    = (state_reg != IDLE);
    assign done_o    = (state_reg == DONE);
    assign raddr_o   = fptr_reg;
    assign tx.tvalid = tvalid_reg;
    assign tx.tdata  = tdata_reg;
    assign tx.tlast  = tlast_reg;
endmodule

// File: tb/tb_aidc_lite_comp_buffer_drain.sv
// Directed bench for the buffer drain engine: models the 16-entry buffer with
// a combinational read port and checks beats, tlast, done timing and reset.
module tb_aidc_lite_comp_buffer_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [3:0]  saddr_i;
    logic [4:0]  wcnt_i;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  raddr_o;
    logic [63:0] rdata_i;
    logic [63:0] mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    // Results recorded by run_cmd for the calling test to compare.
    logic [63:0] beat_q [$];
    logic        last_q [$];
    logic [3:0]  load_q [$];
    int first_v, done_c, hs_last_c, n_done, stall_bad;
    logic busy_after;

    aidc_lite_comp_buffer_drain_if #(.DATA_W(64)) tx ();

    aidc_lite_comp_buffer_drain #(.DATA_W(64), .ADDR_W(4), .DEPTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .saddr_i (saddr_i),
        .wcnt_i  (wcnt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .raddr_o (raddr_o),
        .rdata_i (rdata_i),
        .tx      (tx.master)
    );

    always #5 clk = ~clk;
    assign rdata_i = mem[raddr_o];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and records the stream; performs no comparisons.
    task automatic run_cmd(input logic [3:0] sa, input logic [4:0] wc,
                           input logic [31:0] pat, input int pat_len, input bit poke);
        int c;
        int vcount;
        logic prev_stall;
        logic [63:0] prev_data;
        beat_q.delete(); last_q.delete(); load_q.delete();
        first_v = -1; done_c = -1; hs_last_c = -1; n_done = 0; stall_bad = 0;
        busy_after = 1'bx;
        vcount = 0; prev_stall = 1'b0; prev_data = '0;
        start_i = 1'b1; saddr_i = sa; wcnt_i = wc; tx.tready = 1'b1;
        step();
        c = 1;
        while (c < 200) begin
            if (poke && c == 3) begin
                start_i = 1'b1; saddr_i = 4'd9; wcnt_i = 5'd2;
            end else begin
                start_i = 1'b0;
            end
            tx.tready = (vcount < pat_len) ? pat[vcount] : 1'b1;
            if (c == 1 && wc != 5'd0) load_q.push_back(raddr_o);
            if (tx.tvalid) begin
                if (first_v < 0) first_v = c;
                if (prev_stall && tx.tdata !== prev_data) stall_bad++;
                if (tx.tready) begin
                    beat_q.push_back(tx.tdata);
                    last_q.push_back(tx.tlast);
                    hs_last_c = c;
                    if (!tx.tlast) load_q.push_back(raddr_o);
                end
                prev_stall = !tx.tready;
                prev_data  = tx.tdata;
                vcount++;
            end else begin
                prev_stall = 1'b0;
            end
            if (done_o) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c == done_c + 1) begin
                busy_after = busy_o;
                break;
            end
            step();
            c++;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; saddr_i = '0; wcnt_i = '0; tx.tready = 1'b0;
        step(); step();
        n_cmp++; if (tx.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b want=0", tx.tvalid); end
        n_cmp++; if (tx.tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got=%b want=0", tx.tlast); end
        n_cmp++; if (tx.tdata !== 64'h0) begin n_bad++; $display("FAIL reset_tdata got=%h want=0", tx.tdata); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_cmp++; if (raddr_o !== 4'd0) begin n_bad++; $display("FAIL reset_raddr got=%0d want=0", raddr_o); end
        rst = 1'b0;
        step();
        $display("reset: tvalid=%b busy=%b done=%b raddr=%0d", tx.tvalid, busy_o, done_o, raddr_o);
    endtask

    task automatic test_basic();
        run_cmd(4'd0, 5'd4, 32'hFFFF_FFFF, 32, 1'b0);
        $display("basic: beats=%0d first_v=%0d done_c=%0d", beat_q.size(), first_v, done_c);
        n_cmp++; if (beat_q.size() !== 4) begin n_bad++; $display("FAIL basic_count got=%0d want=4", beat_q.size()); end
        for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
            n_cmp++; if (beat_q[i] !== 64'h1111_0000_0000_0000 + 64'(i)) begin n_bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, beat_q[i], 64'h1111_0000_0000_0000 + 64'(i)); end
            n_cmp++; if (last_q[i] !== (i == 3)) begin n_bad++; $display("FAIL basic_last[%0d] got=%b want=%b", i, last_q[i], (i == 3)); end
        end
        n_cmp++; if (first_v !== 2) begin n_bad++; $display("FAIL basic_first_valid got=%0d want=2", first_v); end
        n_cmp++; if (hs_last_c !== 5) begin n_bad++; $display("FAIL basic_last_cycle got=%0d want=5", hs_last_c); end
        n_cmp++; if (done_c !== 6) begin n_bad++; $display("FAIL basic_done_cycle got=%0d want=6", done_c); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL basic_done_pulses got=%0d want=1", n_done); end
        n_cmp++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got=%b want=0", busy_after); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_a [4];
        exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        run_cmd(4'd14, 5'd4, 32'hFFFF_FFFF, 32, 1'b0);
        $display("wrap: beats=%0d loads=%0d done_c=%0d", beat_q.size(), load_q.size(), done_c);
        n_cmp++; if (load_q.size() !== 4) begin n_bad++; $display("FAIL wrap_nloads got=%0d want=4", load_q.size()); end
        for (int i = 0; i < 4 && i < load_q.size() && i < beat_q.size(); i++) begin
            n_cmp++; if (load_q[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_raddr[%0d] got=%0d want=%0d", i, load_q[i], exp_a[i]); end
            n_cmp++; if (beat_q[i] !== mem[exp_a[i]]) begin n_bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, beat_q[i], mem[exp_a[i]]); end
            n_cmp++; if (last_q[i] !== (i == 3)) begin n_bad++; $display("FAIL wrap_last[%0d] got=%b want=%b", i, last_q[i], (i == 3)); end
        end
        n_cmp++; if (done_c !== 6) begin n_bad++; $display("FAIL wrap_done_cycle got=%0d want=6", done_c); end
    endtask

    task automatic test_backpressure();
        // ready per valid cycle: 1,0,0,1,0,1
        run_cmd(4'd5, 5'd3, 32'b101001, 6, 1'b0);
        $display("backpressure: beats=%0d hs_last=%0d done_c=%0d stall_bad=%0d", beat_q.size(), hs_last_c, done_c, stall_bad);
        n_cmp++; if (beat_q.size() !== 3) begin n_bad++; $display("FAIL bp_count got=%0d want=3", beat_q.size()); end
        for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
            n_cmp++; if (beat_q[i] !== mem[5 + i]) begin n_bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, beat_q[i], mem[5 + i]); end
            n_cmp++; if (last_q[i] !== (i == 2)) begin n_bad++; $display("FAIL bp_last[%0d] got=%b want=%b", i, last_q[i], (i == 2)); end
        end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stall_hold got=%0d changes want=0", stall_bad); end
        n_cmp++; if (hs_last_c !== 7) begin n_bad++; $display("FAIL bp_last_hs_cycle got=%0d want=7", hs_last_c); end
        n_cmp++; if (done_c !== 8) begin n_bad++; $display("FAIL bp_done_cycle got=%0d want=8", done_c); end
    endtask

    task automatic test_boundary();
        run_cmd(4'd6, 5'd0, 32'hFFFF_FFFF, 32, 1'b0);
        $display("count0: beats=%0d first_v=%0d done_c=%0d", beat_q.size(), first_v, done_c);
        n_cmp++; if (beat_q.size() !== 0) begin n_bad++; $display("FAIL cnt0_beats got=%0d want=0", beat_q.size()); end
        n_cmp++; if (first_v !== -1) begin n_bad++; $display("FAIL cnt0_valid_seen got=%0d want=-1", first_v); end
        n_cmp++; if (done_c !== 1) begin n_bad++; $display("FAIL cnt0_done_cycle got=%0d want=1", done_c); end

        run_cmd(4'd7, 5'd1, 32'hFFFF_FFFF, 32, 1'b0);
        $display("count1: beats=%0d done_c=%0d", beat_q.size(), done_c);
        n_cmp++; if (beat_q.size() !== 1) begin n_bad++; $display("FAIL cnt1_beats got=%0d want=1", beat_q.size()); end
        if (beat_q.size() > 0) begin
            n_cmp++; if (beat_q[0] !== mem[7]) begin n_bad++; $display("FAIL cnt1_data got=%h want=%h", beat_q[0], mem[7]); end
            n_cmp++; if (last_q[0] !== 1'b1) begin n_bad++; $display("FAIL cnt1_last got=%b want=1", last_q[0]); end
        end
        n_cmp++; if (done_c !== 3) begin n_bad++; $display("FAIL cnt1_done_cycle got=%0d want=3", done_c); end

        run_cmd(4'd3, 5'd16, 32'hFFFF_FFFF, 32, 1'b0);
        $display("count16: beats=%0d done_c=%0d", beat_q.size(), done_c);
        n_cmp++; if (beat_q.size() !== 16) begin n_bad++; $display("FAIL cnt16_beats got=%0d want=16", beat_q.size()); end
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            n_cmp++; if (beat_q[i] !== mem[(3 + i) % 16]) begin n_bad++; $display("FAIL cnt16_data[%0d] got=%h want=%h", i, beat_q[i], mem[(3 + i) % 16]); end
            n_cmp++; if (last_q[i] !== (i == 15)) begin n_bad++; $display("FAIL cnt16_last[%0d] got=%b want=%b", i, last_q[i], (i == 15)); end
        end
        n_cmp++; if (done_c !== 18) begin n_bad++; $display("FAIL cnt16_done_cycle got=%0d want=18", done_c); end

        run_cmd(4'd0, 5'd20, 32'hFFFF_FFFF, 32, 1'b0);
        $display("count20: beats=%0d done_c=%0d", beat_q.size(), done_c);
        n_cmp++; if (beat_q.size() !== 16) begin n_bad++; $display("FAIL cnt20_beats got=%0d want=16", beat_q.size()); end
        if (beat_q.size() == 16) begin
            n_cmp++; if (beat_q[15] !== mem[15]) begin n_bad++; $display("FAIL cnt20_final_data got=%h want=%h", beat_q[15], mem[15]); end
            n_cmp++; if (last_q[15] !== 1'b1) begin n_bad++; $display("FAIL cnt20_final_last got=%b want=1", last_q[15]); end
        end
        n_cmp++; if (done_c !== 18) begin n_bad++; $display("FAIL cnt20_done_cycle got=%0d want=18", done_c); end
    endtask

    task automatic test_start_busy();
        int extra_v;
        int extra_busy;
        run_cmd(4'd2, 5'd5, 32'hFFFF_FFFF, 32, 1'b1);
        $display("start_busy: beats=%0d done_c=%0d n_done=%0d", beat_q.size(), done_c, n_done);
        n_cmp++; if (beat_q.size() !== 5) begin n_bad++; $display("FAIL busy_beats got=%0d want=5", beat_q.size()); end
        for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
            n_cmp++; if (beat_q[i] !== mem[2 + i]) begin n_bad++; $display("FAIL busy_data[%0d] got=%h want=%h", i, beat_q[i], mem[2 + i]); end
        end
        n_cmp++; if (done_c !== 7) begin n_bad++; $display("FAIL busy_done_cycle got=%0d want=7", done_c); end
        extra_v = 0; extra_busy = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tx.tvalid) extra_v++;
            if (busy_o) extra_busy++;
        end
        n_cmp++; if (extra_v !== 0) begin n_bad++; $display("FAIL busy_queued_beats got=%0d want=0", extra_v); end
        n_cmp++; if (extra_busy !== 0) begin n_bad++; $display("FAIL busy_queued_cmd got=%0d busy cycles want=0", extra_busy); end
    endtask

    task automatic test_midstream_reset();
        int extra_done;
        start_i = 1'b1; saddr_i = 4'd4; wcnt_i = 5'd8; tx.tready = 1'b1;
        step();
        start_i = 1'b0;
        step(); step(); step();
        // Two beats accepted; the third word is on the bus.
        n_cmp++; if (tx.tvalid !== 1'b1 || tx.tdata !== mem[6]) begin n_bad++; $display("FAIL mrst_pre tvalid=%b data=%h want 1/%h", tx.tvalid, tx.tdata, mem[6]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("mid_reset: tvalid=%b busy=%b done=%b", tx.tvalid, busy_o, done_o);
        n_cmp++; if (tx.tvalid !== 1'b0) begin n_bad++; $display("FAIL mrst_tvalid got=%b want=0", tx.tvalid); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got=%b want=0", busy_o); end
        n_cmp++; if (tx.tlast !== 1'b0) begin n_bad++; $display("FAIL mrst_tlast got=%b want=0", tx.tlast); end
        extra_done = done_o ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done_o || tx.tvalid) extra_done++;
        end
        n_cmp++; if (extra_done !== 0) begin n_bad++; $display("FAIL mrst_no_done got=%0d want=0", extra_done); end
        run_cmd(4'd11, 5'd3, 32'hFFFF_FFFF, 32, 1'b0);
        $display("post_reset: beats=%0d done_c=%0d", beat_q.size(), done_c);
        n_cmp++; if (beat_q.size() !== 3) begin n_bad++; $display("FAIL mrst_fresh_beats got=%0d want=3", beat_q.size()); end
        for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
            n_cmp++; if (beat_q[i] !== mem[11 + i]) begin n_bad++; $display("FAIL mrst_fresh_data[%0d] got=%h want=%h", i, beat_q[i], mem[11 + i]); end
        end
        n_cmp++; if (done_c !== 5) begin n_bad++; $display("FAIL mrst_fresh_done got=%0d want=5", done_c); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h1111_0000_0000_0000 + 64'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_boundary();
        test_start_busy();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
